// File: rtl/udp_writer.sv
// Purpose: captures a CAPACITY-byte word on load, pulses trig to udp_packet, streams bytes MSB-first (show-ahead).
// Latency: load at edge N -> trig/busy/byte0 in cycle N+1; read_en at edge M -> next byte (or done) in cycle M+1.
// Backpressure: read_en is the consumer strobe; gaps are legal up to TIMEOUT idle cycles, load while busy is dropped.
module udp_writer #(
    parameter int CAPACITY = 6,
    parameter int TIMEOUT  = 1_000_000
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    load,
    input  logic [CAPACITY*8-1:0]   i_data,
    output logic                    trig,
    output logic [15:0]             data_len,
    input  logic                    read_en,
    output logic [7:0]              o_data,
    output logic                    busy,
    output logic                    done,
    output logic                    drop,
    output logic                    timeout
);

    localparam int IDXW = (CAPACITY > 1) ? $clog2(CAPACITY) : 1;
    localparam int CNTW = $clog2(TIMEOUT + 1);
    localparam int TOP  = CAPACITY * 8 - 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;

    logic [1:0]          r_state;
    logic [TOP:0]        r_shift;
    logic [IDXW-1:0]     r_idx;
    logic [CNTW-1:0]     r_cnt;
    logic                r_trig;
    logic                r_busy;
    logic                r_done;
    logic                r_drop;
    logic                r_timeout;
    logic [7:0]          r_odata;

    logic [TOP:0]        w_shift_nxt;
    logic [CNTW-1:0]     w_cnt_inc;
    logic                w_last;
    logic                w_expire;

    // Next-byte view, idle-counter increment and terminal conditions for the active transfer
    always_comb begin
        w_shift_nxt = r_shift << 8;
        w_cnt_inc   = r_cnt + CNTW'(1);
        w_last      = (r_idx == IDXW'(CAPACITY - 1));
        // Expiry is the edge at which the idle counter would reach TIMEOUT
        w_expire    = (w_cnt_inc == CNTW'(TIMEOUT));
    end

    // Transfer FSM: capture, one-cycle request, byte streaming with idle watchdog
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_trig    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_drop    <= 1'b0;
            r_timeout <= 1'b0;
            r_odata   <= 8'h00;
        end else begin
            r_trig    <= 1'b0;
            r_done    <= 1'b0;
            r_drop    <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_shift <= i_data;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_trig  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_odata <= i_data[TOP -: 8];
                        r_state <= S_REQ;
                    end
                end
                S_REQ, S_XFER: begin
                    // Any load during a transfer, including its final cycle, is rejected
                    r_drop <= load;
                    if (r_state == S_REQ) begin
                        r_state <= S_XFER;
                    end
                    if (read_en) begin
                        // A consume always beats a coincident watchdog expiry
                        r_cnt   <= '0;
                        r_shift <= w_shift_nxt;
                        if (w_last) begin
                            r_idx   <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_odata <= 8'h00;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + IDXW'(1);
                            r_odata <= w_shift_nxt[TOP -: 8];
                        end
                    end else if (w_expire) begin
                        // Abort: counter parks at TIMEOUT, remaining bytes are abandoned
                        r_cnt     <= w_cnt_inc;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_odata   <= 8'h00;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_odata <= 8'h00;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign trig     = r_trig;
    assign data_len = 16'(CAPACITY);
    assign o_data   = r_odata;
    assign busy     = r_busy;
    assign done     = r_done;
    assign drop     = r_drop;
    assign timeout  = r_timeout;

endmodule

// File: tb/tb_udp_writer.sv
// Bench for udp_writer: 6-byte instance (TIMEOUT=16) plus a 1-byte instance.
// Expected bytes are queued at load time and popped on every consumed read_en.
// Pulse outputs are tallied on the falling edge and checked per scenario.
module tb_udp_writer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        load;
    logic [47:0] i_data;
    logic        read_en;
    logic        trig;
    logic [15:0] data_len;
    logic [7:0]  o_data;
    logic        busy;
    logic        done;
    logic        drop;
    logic        timeout;

    logic        load1;
    logic [7:0]  i_data1;
    logic        read_en1;
    logic        trig1;
    logic [15:0] data_len1;
    logic [7:0]  o_data1;
    logic        busy1;
    logic        done1;
    logic        drop1;
    logic        timeout1;

    int n_vec = 0;
    int n_err = 0;
    int n_done = 0;
    int n_to = 0;
    int n_drop = 0;
    int n_trig = 0;

    logic [7:0] exp_q[$];

    udp_writer #(.CAPACITY(6), .TIMEOUT(16)) u_dut (
        .clk(clk), .rstn(rstn), .load(load), .i_data(i_data),
        .trig(trig), .data_len(data_len), .read_en(read_en), .o_data(o_data),
        .busy(busy), .done(done), .drop(drop), .timeout(timeout)
    );

    udp_writer #(.CAPACITY(1), .TIMEOUT(16)) u_dut1 (
        .clk(clk), .rstn(rstn), .load(load1), .i_data(i_data1),
        .trig(trig1), .data_len(data_len1), .read_en(read_en1), .o_data(o_data1),
        .busy(busy1), .done(done1), .drop(drop1), .timeout(timeout1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done)    n_done++;
        if (timeout) n_to++;
        if (drop)    n_drop++;
        if (trig)    n_trig++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Load a payload from IDLE; returns positioned in the REQ cycle
    task automatic load_payload(input logic [47:0] d);
        i_data = d;
        load   = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back(d[47-8*i -: 8]);
        tick();
        load = 1'b0;
        chk("trig_req", 32'(trig), 32'd1);
        chk("busy_req", 32'(busy), 32'd1);
    endtask

    // One cycle with read_en=en; consumed bytes are popped from the scoreboard
    task automatic rd(input logic en);
        logic [7:0] e;
        read_en = en;
        if (en) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
            chk("o_data", 32'(o_data), 32'(e));
        end else if (exp_q.size() != 0) begin
            chk("o_data_hold", 32'(o_data), 32'(exp_q[0]));
        end
        tick();
        read_en = 1'b0;
    endtask

    task automatic chk_idle_done(input string tag);
        chk({tag, "_done"},  32'(done),   32'd1);
        chk({tag, "_busy"},  32'(busy),   32'd0);
        chk({tag, "_odata"}, 32'(o_data), 32'd0);
    endtask

    initial begin
        int d0, t0, p0, g0;
        rstn = 1'b0; load = 1'b0; i_data = '0; read_en = 1'b0;
        load1 = 1'b0; i_data1 = '0; read_en1 = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_trig", 32'(trig), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_odata", 32'(o_data), 32'd0);
        chk("data_len6", 32'(data_len), 32'd6);
        chk("data_len1", 32'(data_len1), 32'd1);
        rstn = 1'b1;
        tick();

        // Continuous read from the REQ cycle
        d0 = n_done; g0 = n_trig;
        load_payload(48'h112233445566);
        rd(1'b1);
        chk("trig_one_cycle", 32'(trig), 32'd0);
        for (int i = 0; i < 5; i++) rd(1'b1);
        chk_idle_done("cont");
        chk("cont_sb_empty", 32'(exp_q.size()), 32'd0);
        // read_en in IDLE is ignored
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        chk("idle_rd_done", 32'(done), 32'd0);
        chk("idle_rd_busy", 32'(busy), 32'd0);
        chk("idle_rd_odata", 32'(o_data), 32'd0);
        chk("cont_done_cnt", 32'(n_done - d0), 32'd1);
        chk("cont_trig_cnt", 32'(n_trig - g0), 32'd1);

        // Gapped read 1,0,0,1,1,0,1,1,1
        d0 = n_done; t0 = n_to;
        load_payload(48'h112233445566);
        rd(1'b1); rd(1'b0); rd(1'b0); rd(1'b1); rd(1'b1);
        rd(1'b0); rd(1'b1); rd(1'b1); rd(1'b1);
        chk_idle_done("gap");
        tick();
        chk("gap_done_cnt", 32'(n_done - d0), 32'd1);
        chk("gap_to_cnt", 32'(n_to - t0), 32'd0);

        // Load while busy: during byte 3 and on the final read_en
        p0 = n_drop;
        load_payload(48'h112233445566);
        rd(1'b1); rd(1'b1);
        i_data = 48'hAABBCCDDEEFF;
        load   = 1'b1;
        rd(1'b1);
        load   = 1'b0;
        chk("drop_mid", 32'(drop), 32'd1);
        rd(1'b1); rd(1'b1);
        load = 1'b1;
        rd(1'b1);
        load = 1'b0;
        chk_idle_done("drop_last");
        chk("drop_last", 32'(drop), 32'd1);
        tick();
        chk("drop_cnt", 32'(n_drop - p0), 32'd2);
        load_payload(48'hAABBCCDDEEFF);
        for (int i = 0; i < 6; i++) rd(1'b1);
        chk_idle_done("after_drop");

        // Timeout A: no read_en; pulse 16 cycles after the trig cycle
        tick();
        d0 = n_done; t0 = n_to;
        load_payload(48'h0102030405A6);
        for (int i = 0; i < 15; i++) tick();
        chk("toA_busy_pre", 32'(busy), 32'd1);
        chk("toA_timeout_pre", 32'(timeout), 32'd0);
        tick();
        chk("toA_timeout", 32'(timeout), 32'd1);
        chk("toA_busy", 32'(busy), 32'd0);
        chk("toA_odata", 32'(o_data), 32'd0);
        exp_q.delete();
        tick();
        chk("toA_timeout_clr", 32'(timeout), 32'd0);
        chk("toA_done_cnt", 32'(n_done - d0), 32'd0);
        chk("toA_to_cnt", 32'(n_to - t0), 32'd1);

        // Timeout B: final read_en lands in the expiry cycle
        d0 = n_done; t0 = n_to;
        load_payload(48'h112233445566);
        for (int i = 0; i < 5; i++) rd(1'b1);
        for (int i = 0; i < 15; i++) rd(1'b0);
        chk("toB_busy_pre", 32'(busy), 32'd1);
        rd(1'b1);
        chk_idle_done("toB");
        chk("toB_timeout", 32'(timeout), 32'd0);
        tick();
        chk("toB_done_cnt", 32'(n_done - d0), 32'd1);
        chk("toB_to_cnt", 32'(n_to - t0), 32'd0);

        // Reset after two bytes consumed
        d0 = n_done; t0 = n_to;
        load_payload(48'h112233445566);
        rd(1'b1); rd(1'b1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        exp_q.delete();
        chk("mrst_trig", 32'(trig), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_drop", 32'(drop), 32'd0);
        chk("mrst_timeout", 32'(timeout), 32'd0);
        chk("mrst_odata", 32'(o_data), 32'd0);
        tick();
        chk("mrst_done_cnt", 32'(n_done - d0), 32'd0);
        chk("mrst_to_cnt", 32'(n_to - t0), 32'd0);
        load_payload(48'hC1C2C3C4C5C6);
        for (int i = 0; i < 6; i++) rd(1'b1);
        chk_idle_done("mrst_fresh");

        // Single-byte instance: read_en in the REQ cycle
        i_data1 = 8'h5A;
        load1   = 1'b1;
        tick();
        load1   = 1'b0;
        chk("cap1_trig", 32'(trig1), 32'd1);
        chk("cap1_busy", 32'(busy1), 32'd1);
        chk("cap1_odata", 32'(o_data1), 32'h5A);
        read_en1 = 1'b1;
        tick();
        read_en1 = 1'b0;
        chk("cap1_done", 32'(done1), 32'd1);
        chk("cap1_busy_end", 32'(busy1), 32'd0);
        chk("cap1_odata_end", 32'(o_data1), 32'd0);
        chk("cap1_timeout", 32'(timeout1), 32'd0);
        tick();
        chk("cap1_done_clr", 32'(done1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
